if_m: RTL and testbench
=======================

# if_m

Instruction-fetch stage of the single-cycle teaching CPU. Holds a 32-bit program counter, drives a 64-word × 32-bit instruction ROM, and presents one fetched instruction per clock on `Inst_code` to the decode stage. There is no branch or jump input; the PC advances sequentially and wraps around the ROM.

## Interface
- `ROM_DEPTH`, default 64: number of 32-bit instruction words. Must be a power of two.
- `ADDR_W`, default 6: ROM word-address width, equal to log2(`ROM_DEPTH`).
- `clka`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Reset is asynchronous and active-high.
- `Inst_code`: output, 32 bits. Registered instruction word.

## Operation
- **PC register:** 32-bit `pc`, reset value 32'h0000_0000.
  - Each rising edge with `rst`=0: `pc <= pc + 4`.
  - The add is 32-bit modulo; the carry is discarded.
- **ROM address:** `pc[ADDR_W+1:2]`.
  - `pc[1:0]` is ignored and is always 0 by construction.
  - Upper PC bits are ignored, so fetch wraps every `ROM_DEPTH*4` bytes (256 bytes by default).
- **ROM read:** synchronous, matching block-ROM behaviour.
  - Each rising edge with `rst`=0: `Inst_code <= rom[pc[ADDR_W+1:2]]`, using the pre-edge `pc`.
- **ROM contents:** constant `IF_ROM_INIT` from the shared package. Words 0..7 are:
  - 0: 32'h2001_0008 (addi $1,$0,8)
  - 1: 32'h2002_0002 (addi $2,$0,2)
  - 2: 32'h0022_1820 (add $3,$1,$2)
  - 3: 32'h0022_2022 (sub $4,$1,$2)
  - 4: 32'h0022_2824 (and $5,$1,$2)
  - 5: 32'h0022_3025 (or $6,$1,$2)
  - 6: 32'h0022_382A (slt $7,$1,$2)
  - 7: 32'h0800_0000 (j 0)
  - Words 8..63 are 32'h0000_0000.
  - The ROM is read-only and has no write port.
- **Reset:**
  - `rst`=1 forces `pc`=0 and `Inst_code`=32'h0000_0000 immediately, without waiting for a clock edge.
  - Both registers hold those values while `rst` is high.

## Timing
- Latency: one cycle from a PC value to its instruction appearing on `Inst_code`.
- First rising edge after `rst` falls: `Inst_code`=rom[0] and `pc`=4.
- Nth rising edge after `rst` falls: `Inst_code`=rom[(N-1) mod ROM_DEPTH].
- Wrap: the edge after `Inst_code`=rom[63] yields rom[0]. At that point `pc` holds 256, and `pc` continues counting upward.
- Reset mid-run: asserting `rst` between edges clears `Inst_code` and `pc` at once, without waiting for an edge. After release, the sequence restarts at rom[0].
- `rst` deasserting coincident with a rising edge: that edge does not advance the PC. The first fetch happens on the following edge.
- No stall or enable input; the PC advances on every non-reset edge.

## Structure
- Shared package `if_pkg`:
  - `IF_ROM_INIT`: array of 64 × 32-bit words.
  - `IF_PC_RESET` = 32'h0.
  - `IF_PC_STEP` = 4.
- One natural sub-module, `inst_rom`:
  - Inputs: `clka`, `rst`, `addr[ADDR_W-1:0]`.
  - Output: registered `dout[31:0]`, cleared asynchronously by `rst`.
  - Contents initialised from `IF_ROM_INIT`.
- Top level: PC register, +4 adder, and the `inst_rom` instance.

## Test plan
- **Reset hold:** `clka` period 100 ns (toggling every 50 ns, starting high), `rst`=1 for 100 ns. Over that window `Inst_code` stays 32'h0000_0000 across clock edges.
- **Sequential fetch:** release `rst`. Successive rising edges give 32'h2001_0008, 32'h2002_0002, 32'h0022_1820, 32'h0022_2022, 32'h0022_2824, 32'h0022_3025, 32'h0022_382A, 32'h0800_0000, then 32'h0000_0000.
- **Wrap:** run 64 edges after reset release, then one more. The 65th edge gives 32'h2001_0008 again.
- **Async reset mid-run:** after 5 fetches, assert `rst` at mid-cycle.
  - `Inst_code` goes to 0 before the next edge.
  - Release `rst`; the next edge gives 32'h2001_0008.
- **Reset/edge coincidence:** deassert `rst` exactly at a rising edge. `Inst_code` stays 0 at that edge and shows 32'h2001_0008 on the next edge.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: PC reset/step and ROM image.
package if_pkg;

   localparam int IF_ROM_WORDS = 64;

   localparam logic [31:0] IF_PC_RESET = 32'h0000_0000;
   localparam logic [31:0] IF_PC_STEP  = 32'd4;

   // Element 0 is the least-significant slice, so the program reads bottom-up.
   localparam logic [IF_ROM_WORDS-1:0][31:0] IF_ROM_INIT = {
      {56{32'h0000_0000}},
      32'h0800_0000,   // 7: j 0
      32'h0022_382A,   // 6: slt $7,$1,$2
      32'h0022_3025,   // 5: or  $6,$1,$2
      32'h0022_2824,   // 4: and $5,$1,$2
      32'h0022_2022,   // 3: sub $4,$1,$2
      32'h0022_1820,   // 2: add $3,$1,$2
      32'h2002_0002,   // 1: addi $2,$0,2
      32'h2001_0008    // 0: addi $1,$0,8
   };

endpackage

// File: rtl/if_m_inst_rom.sv
// Read-only instruction memory with a registered output port.
module inst_rom
   import if_pkg::*;
#(
   parameter int ROM_DEPTH = 64,
   parameter int ADDR_W    = 6
) (
   input  logic              clka,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [31:0]       dout
);

   logic [31:0] rom [ROM_DEPTH];

   // Words beyond the packaged image (only when the ROM is enlarged) read as zero.
   genvar gi;
   generate
      for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
         if (gi < IF_ROM_WORDS) begin : g_init
            assign rom[gi] = IF_ROM_INIT[gi];
         end else begin : g_zero
            assign rom[gi] = 32'h0000_0000;
         end
      end
   endgenerate

   // Synchronous read; reset clears the output word immediately.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         dout <= 32'h0000_0000;
      end else begin
         dout <= rom[addr];
      end
   end

endmodule

// File: rtl/if_m.sv
// Instruction-fetch stage: sequential PC feeding a block-style instruction ROM.
module if_m
   import if_pkg::*;
#(
   parameter int ROM_DEPTH = 64,
   parameter int ADDR_W    = 6
) (
   input  logic        clka,
   input  logic        rst,
   output logic [31:0] Inst_code
);

   logic [31:0] pc;
   logic [31:0] pc_next;

   // 32-bit modulo increment; only the word-address bits reach the ROM, so fetch wraps.
   assign pc_next = pc + IF_PC_STEP;

   // Program counter advances one word per non-reset edge.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         pc <= IF_PC_RESET;
      end else begin
         pc <= pc_next;
      end
   end

   inst_rom #(
      .ROM_DEPTH (ROM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_inst_rom (
      .clka (clka),
      .rst  (rst),
      .addr (pc[ADDR_W+1:2]),
      .dout (Inst_code)
   );

endmodule

// File: tb/tb_if_m.sv
// Self-checking bench for if_m: scoreboard of expected fetch words per clock edge.
module tb_if_m;

   logic        clka;
   logic        rst;
   logic [31:0] Inst_code;

   logic [31:0] exp_q[$];
   int          fetch_idx;
   int          n_checks;
   int          n_pass;

   if_m #(
      .ROM_DEPTH (64),
      .ADDR_W    (6)
   ) dut (
      .clka      (clka),
      .rst       (rst),
      .Inst_code (Inst_code)
   );

   // 100 ns period, starting high.
   initial clka = 1'b1;
   always #50 clka = ~clka;

   // Reference program image, written independently of the package.
   function automatic logic [31:0] rom_model(input int n);
      logic [31:0] w;
      case (n % 64)
         0:       w = 32'h2001_0008;
         1:       w = 32'h2002_0002;
         2:       w = 32'h0022_1820;
         3:       w = 32'h0022_2022;
         4:       w = 32'h0022_2824;
         5:       w = 32'h0022_3025;
         6:       w = 32'h0022_382A;
         7:       w = 32'h0800_0000;
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %08h expected %08h @%0t", tag, got, exp, $time);
      end else begin
         n_pass++;
         $display("chk  %s: got %08h expected %08h ok @%0t", tag, got, exp, $time);
      end
   endtask

   // Pop the oldest expectation and compare it to the current output.
   task automatic sb_compare(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, Inst_code, ~Inst_code);
      end else begin
         e = exp_q.pop_front();
         check(tag, Inst_code, e);
      end
   endtask

   // One clock edge: push what that edge must produce, then sample 1 ns after it.
   task automatic tick(input string tag);
      if (rst) begin
         exp_q.push_back(32'h0000_0000);
         fetch_idx = 0;
      end else begin
         exp_q.push_back(rom_model(fetch_idx));
         fetch_idx++;
      end
      @(posedge clka);
      #1;
      sb_compare(tag);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish @%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      fetch_idx = 0;
      rst       = 1'b1;

      // Reset hold across the first clock period.
      #25;
      exp_q.push_back(32'h0000_0000);
      sb_compare("rst_hold_a");
      #50;
      exp_q.push_back(32'h0000_0000);
      sb_compare("rst_hold_b");
      check("rst_pc", dut.pc, 32'h0000_0000);

      // Release exactly at the edge (t=100). The nonblocking update lands after
      // the edge has been evaluated, so the edge sees rst still high.
      exp_q.push_back(32'h0000_0000);
      fetch_idx = 0;
      @(posedge clka);
      rst <= 1'b0;
      #1;
      sb_compare("coincide");
      check("coincide_pc", dut.pc, 32'h0000_0000);

      // Sequential fetch through the program and into the zero words.
      tick("fetch0");
      check("pc_first", dut.pc, 32'd4);
      for (int i = 1; i < 9; i++) tick($sformatf("fetch%0d", i));

      // Run on to 64 fetches, then the wrap edge.
      for (int i = 9; i < 64; i++) tick($sformatf("fetch%0d", i));
      check("pc_at_wrap", dut.pc, 32'd256);
      tick("wrap");
      check("pc_after_wrap", dut.pc, 32'd260);

      // Four more fetches, then an asynchronous reset mid-cycle.
      for (int i = 0; i < 4; i++) tick($sformatf("post_wrap%0d", i));
      #49;
      rst = 1'b1;
      #1;
      exp_q.push_back(32'h0000_0000);
      sb_compare("async_rst");
      check("async_rst_pc", dut.pc, 32'h0000_0000);
      tick("rst_held_edge");

      // Release between edges; fetch restarts at word 0.
      #30;
      rst = 1'b0;
      tick("restart0");
      tick("restart1");
      tick("restart2");

      if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
